// File: rtl/instruction_fetch_unit_if.sv
// Signal bundle between the fetch unit, the instruction ROM and the decode stage.
// The master side is the fetch unit; the slave side is the ROM/decode/redirect environment.
interface instruction_fetch_unit_if;
    logic        HSEL1;
    logic        rd_en_rom;
    logic [31:0] address_rom;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    modport master (
        output HSEL1,
        output rd_en_rom,
        output address_rom,
        output if_valid,
        output if_instr,
        output if_pc,
        input  instruction,
        input  redirect_valid,
        input  redirect_pc,
        input  if_ready
    );

    modport slave (
        input  HSEL1,
        input  rd_en_rom,
        input  address_rom,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        output instruction,
        output redirect_valid,
        output redirect_pc,
        output if_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited ROM reads, buffers responses in a
// prefetch FIFO and hands them to decode over valid/ready; redirects flush the pipe.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input logic                      clk,
    input logic                      reset,
    instruction_fetch_unit_if.master fetch
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          rd_en_q, rd_en_d;
    logic [31:0]   addr_q, addr_d;
    logic          resp_pending_q, resp_pending_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic          drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    logic [31:0] mem_instr [DEPTH];
    logic [31:0] mem_pc    [DEPTH];

    logic          redirect;
    logic          push;
    logic          pop;
    logic          not_empty;
    logic          issue;
    logic          credit_ok;
    logic [CW-1:0] count_after;
    logic [CW-1:0] credit;
    logic [31:0]   issue_pc;

    assign redirect  = fetch.redirect_valid;
    assign not_empty = (count_q != '0);
    assign pop       = not_empty && fetch.if_ready;
    // A response is written unless it belongs to a request killed by a redirect.
    assign push      = resp_pending_q && !drop_q && !redirect;

    always_comb begin
        count_after = '0;
        credit      = '0;
        credit_ok   = 1'b0;
        issue       = 1'b0;
        issue_pc    = pc_q;
        state_d     = state_q;
        pc_d        = pc_q;
        rd_en_d     = 1'b0;
        addr_d      = addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (redirect) begin
            count_after = '0;
            issue_pc    = fetch.redirect_pc & ~32'h3;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
        end else begin
            count_after = count_q + CW'(push) - CW'(pop);
            wr_ptr_d    = wr_ptr_q + PW'(push);
            rd_ptr_d    = rd_ptr_q + PW'(pop);
        end
        count_d = count_after;

        // The request currently on the bus still owns a slot until its data lands.
        credit    = count_after + CW'(rd_en_q);
        credit_ok = (credit < DepthCnt);

        unique case (state_q)
            StIdle:        issue = 1'b1;
            StRun, StHold: issue = credit_ok;
            default:       issue = 1'b0;
        endcase
        if (redirect) begin
            issue = 1'b1;
        end

        state_d = issue ? StRun : StHold;
        rd_en_d = issue;
        if (issue) begin
            addr_d = issue_pc;
            pc_d   = issue_pc + 32'd4;
        end else begin
            pc_d   = issue_pc;
        end
    end

    assign resp_pending_d = rd_en_q;
    assign resp_pc_d      = addr_q;
    // Only the read issued in the redirect cycle is still to return; mark it for discard.
    assign drop_d         = redirect && rd_en_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            pc_q           <= RESET_PC;
            rd_en_q        <= 1'b0;
            addr_q         <= '0;
            resp_pending_q <= 1'b0;
            resp_pc_q      <= '0;
            drop_q         <= 1'b0;
            count_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            rd_en_q        <= rd_en_d;
            addr_q         <= addr_d;
            resp_pending_q <= resp_pending_d;
            resp_pc_q      <= resp_pc_d;
            drop_q         <= drop_d;
            count_q        <= count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr_q] <= fetch.instruction;
            mem_pc[wr_ptr_q]    <= resp_pc_q;
        end
    end

    assign fetch.HSEL1       = rd_en_q;
    assign fetch.rd_en_rom   = rd_en_q;
    assign fetch.address_rom = addr_q;
    assign fetch.if_valid    = not_empty;
    assign fetch.if_instr    = not_empty ? mem_instr[rd_ptr_q] : 32'h0;
    assign fetch.if_pc       = not_empty ? mem_pc[rd_ptr_q] : 32'h0;

    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        push |-> (count_q != DepthCnt || pop));
    a_count_bound : assert property (@(posedge clk) disable iff (reset)
        count_q <= DepthCnt);
    a_addr_align  : assert property (@(posedge clk) disable iff (reset)
        addr_q[1:0] == 2'b00);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: reset, streaming, back-pressure, redirects,
// PC wrap (second instance) and mid-stream reset, against hand-computed values.
module tb_instruction_fetch_unit;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    instruction_fetch_unit_if bus ();
    instruction_fetch_unit_if bus_w ();

    instruction_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fetch (bus)
    );

    instruction_fetch_unit #(
        .RESET_PC (32'hFFFF_FFF8),
        .DEPTH    (4)
    ) dut_w (
        .clk   (clk),
        .reset (reset),
        .fetch (bus_w)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0:   rom_word = 32'h0000_0013;
            32'h4:   rom_word = 32'h0020_8113;
            32'h8:   rom_word = 32'h0030_8193;
            default: rom_word = 32'hC0DE_0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    // Registered ROM: data for the address of cycle C appears in cycle C+1.
    always @(posedge clk) begin
        bus.instruction   <= rom_word(bus.address_rom);
        bus_w.instruction <= rom_word(bus_w.address_rom);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_hsel"}, {31'h0, bus.HSEL1}, 32'h0);
        chk({tag, "_rden"}, {31'h0, bus.rd_en_rom}, 32'h0);
        chk({tag, "_addr"}, bus.address_rom, 32'h0);
        chk({tag, "_valid"}, {31'h0, bus.if_valid}, 32'h0);
        chk({tag, "_instr"}, bus.if_instr, 32'h0);
        chk({tag, "_pc"}, bus.if_pc, 32'h0);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, "_valid"}, {31'h0, bus.if_valid}, 32'h1);
        chk({tag, "_pc"}, bus.if_pc, pc);
        chk({tag, "_instr"}, bus.if_instr, ins);
    endtask

    initial begin
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.if_ready       = 1'b1;
        bus_w.redirect_valid = 1'b0;
        bus_w.redirect_pc    = 32'h0;
        bus_w.if_ready       = 1'b1;

        // Reset state and basic streaming, plus PC wrap on the second instance
        @(negedge clk);
        chk_zero("rst");
        chk("rst_w_addr", bus_w.address_rom, 32'h0);
        do_reset();
        tick();
        chk("s1_rden", {31'h0, bus.rd_en_rom}, 32'h1);
        chk("s1_hsel", {31'h0, bus.HSEL1}, 32'h1);
        chk("s1_addr", bus.address_rom, 32'h0);
        chk("s1_w_addr", bus_w.address_rom, 32'hFFFF_FFF8);
        tick();
        chk("s2_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("s2_addr", bus.address_rom, 32'h4);
        tick();
        chk_head("s3", 32'h0, 32'h0000_0013);
        chk("s3_w_pc", bus_w.if_pc, 32'hFFFF_FFF8);
        chk("s3_w_instr", bus_w.if_instr, 32'hC0DE_FFF8);
        chk("s3_w_addr", bus_w.address_rom, 32'h0);
        tick();
        chk_head("s4", 32'h4, 32'h0020_8113);
        chk("s4_w_pc", bus_w.if_pc, 32'hFFFF_FFFC);
        chk("s4_w_instr", bus_w.if_instr, 32'hC0DE_FFFC);
        tick();
        chk_head("s5", 32'h8, 32'h0030_8193);
        chk("s5_w_valid", {31'h0, bus_w.if_valid}, 32'h1);
        chk("s5_w_pc", bus_w.if_pc, 32'h0);
        chk("s5_w_instr", bus_w.if_instr, 32'h0000_0013);

        // Back-pressure: decode stalled for 10 cycles after reset
        bus.if_ready = 1'b0;
        do_reset();
        repeat (4) tick();
        chk("bp4_rden", {31'h0, bus.rd_en_rom}, 32'h1);
        chk("bp4_addr", bus.address_rom, 32'hC);
        tick();
        chk("bp5_rden", {31'h0, bus.rd_en_rom}, 32'h0);
        repeat (5) tick();
        chk("bp10_rden", {31'h0, bus.rd_en_rom}, 32'h0);
        chk_head("bp10", 32'h0, 32'h0000_0013);
        bus.if_ready = 1'b1;
        tick();
        chk_head("bp11", 32'h4, 32'h0020_8113);
        chk("bp11_rden", {31'h0, bus.rd_en_rom}, 32'h1);
        chk("bp11_addr", bus.address_rom, 32'h10);
        tick();
        chk_head("bp12", 32'h8, 32'h0030_8193);
        tick();
        chk_head("bp13", 32'hC, 32'hC0DE_000C);
        tick();
        chk_head("bp14", 32'h10, 32'hC0DE_0010);
        tick();
        chk_head("bp15", 32'h14, 32'hC0DE_0014);

        // Redirect to 0x13 while 0x10 is at the head and being popped
        do_reset();
        repeat (7) tick();
        chk_head("rd7", 32'h10, 32'hC0DE_0010);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h13;
        tick();
        bus.redirect_valid = 1'b0;
        chk("rd8_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("rd8_addr", bus.address_rom, 32'h10);
        tick();
        chk("rd9_valid", {31'h0, bus.if_valid}, 32'h0);
        tick();
        chk_head("rd10", 32'h10, 32'hC0DE_0010);
        tick();
        chk_head("rd11", 32'h14, 32'hC0DE_0014);
        tick();
        chk_head("rd12", 32'h18, 32'hC0DE_0018);

        // Redirect with simultaneous pop, then a second redirect the next cycle
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        tick();
        chk("rr13_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("rr13_addr", bus.address_rom, 32'h40);
        bus.redirect_pc = 32'h80;
        tick();
        bus.redirect_valid = 1'b0;
        chk("rr14_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("rr14_addr", bus.address_rom, 32'h80);
        tick();
        chk("rr15_valid", {31'h0, bus.if_valid}, 32'h0);
        tick();
        chk_head("rr16", 32'h80, 32'hC0DE_0080);
        tick();
        chk_head("rr17", 32'h84, 32'hC0DE_0084);
        tick();
        chk("mr18_rden", {31'h0, bus.rd_en_rom}, 32'h1);

        // Asynchronous reset mid-stream with a request in flight
        reset = 1'b1;
        #1;
        chk_zero("mr");
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        tick();
        chk("mr1_addr", bus.address_rom, 32'h0);
        chk("mr1_rden", {31'h0, bus.rd_en_rom}, 32'h1);
        tick();
        chk("mr2_valid", {31'h0, bus.if_valid}, 32'h0);
        tick();
        chk_head("mr3", 32'h0, 32'h0000_0013);
        tick();
        chk_head("mr4", 32'h4, 32'h0020_8113);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage feeding the decode stage from the instruction ROM. Owns the program counter and drives the ROM request (`HSEL1`, `rd_en_rom`, `address_rom`). Captures the ROM's registered `instruction` response into a small prefetch FIFO. Presents fetched instructions with their PC to decode over a valid/ready handshake, and supports redirect (branch/jump) with a pipeline flush.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 0
- `DEPTH`, 4, prefetch FIFO entries; power of two, ≥2
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `HSEL1`  out  1  ROM slave select; registered; always equal to `rd_en_rom`
- `rd_en_rom`  out  1  ROM read request; registered
- `address_rom`  out  32  byte address of request; registered; bits [1:0] always 0
- `instruction`  in  32  ROM read data, valid the cycle after a request cycle
- `redirect_valid`  in  1  load new PC and flush
- `redirect_pc`  in  32  target PC; bits [1:0] ignored (forced 0)
- `if_valid`  out  1  `if_instr`/`if_pc` hold a fetched instruction
- `if_instr`  out  32  instruction at FIFO head
- `if_pc`  out  32  PC of `if_instr`
- `if_ready`  in  1  decode accepts head this cycle

## Operation
- Request: cycle with `rd_en_rom`=1 fetches `address_rom`. ROM data appears on `instruction` next cycle and is pushed into the FIFO at that cycle's closing edge, tagged with the PC latched at issue.
- PC: increments by 4 per issued request; 32-bit wrap, 0xFFFF_FFFC → 0x0000_0000.
- Issue rule, evaluated each edge: request registered for next cycle iff (FIFO count after this edge's push/pop) + (1 if `rd_en_rom` is high now) < `DEPTH`. The FIFO never overflows; the ROM is never requested without a guaranteed slot.
- Pop: `if_valid` && `if_ready` at an edge removes the head. Push and pop may occur on the same edge; count unchanged.
- `if_valid` = FIFO non-empty. `if_instr`/`if_pc` are stable while `if_valid`=1 and `if_ready`=0.
- Redirect sampled at edge ending cycle N:
  - A pop in N completes first.
  - FIFO is then cleared; any push at that edge is suppressed.
  - PC ← `redirect_pc` & ~3. The request registered for N+1 uses the new PC.
  - A drop flag discards the response arriving in N+1, which belongs to the pre-redirect request from N.
- Redirect when no request is in flight: same behaviour; the drop flag is cleared with nothing discarded.
- Back-to-back redirects: the last one wins; each flushes.
- FSM states:
  - RUN: issuing per the rule above.
  - HOLD: FIFO/credit full, no request. Returns to RUN when the rule permits.
  - IDLE: reset only; exits to RUN at the first edge after reset deasserts.
  - Redirect from any state → RUN.

## Timing
- Reset (async assert) drives outputs immediately:
  - `HSEL1`=`rd_en_rom`=0, `address_rom`=0, `if_valid`=0, `if_instr`=0, `if_pc`=0.
  - PC=`RESET_PC`, FIFO empty, drop flag clear, state IDLE.
- Deassert before edge E0: first request (`address_rom`=`RESET_PC`) visible in cycle after E0. Its data is in the FIFO and `if_valid`=1 two cycles later.
- Fetch latency, request cycle → `if_valid`: 2 cycles.
- Throughput: 1 instruction/cycle sustained with `if_ready` held high.
- Redirect at end of cycle N: `if_valid`=0 in N+1 and N+2; target instruction at `if_pc`=`redirect_pc` in N+3.
- Reset asserted mid-operation: immediate return to reset values. In-flight ROM data is ignored.

## Test plan
- Reset release, `if_ready`=1, ROM words 0x00000013, 0x00208113, 0x00308193 at 0x0, 0x4, 0x8 → `if_valid` from 3rd cycle after E0; `if_pc` 0x0, 0x4, 0x8 on consecutive cycles with matching words; no bubbles.
- `if_ready`=0 for 10 cycles after reset → requests stop once `DEPTH`=4 entries are in FIFO or in flight. `if_pc` holds 0x0. Releasing `if_ready` drains 0x0..0xC in order, then fetching resumes at 0x10 with no loss or duplication.
- Redirect to 0x13 while streaming at PC 0x10 → two bubble cycles; next `if_pc`=0x10 (0x13 masked) carrying the word at 0x10. No pre-redirect instruction appears after the flush.
- Redirect with a simultaneous pop, and two consecutive redirects (0x40 then 0x80) → popped head counted once; stream resumes at 0x80 only.
- PC wrap: `RESET_PC`=0xFFFF_FFF8 → `if_pc` 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Reset asserted mid-stream with a request in flight → all outputs zero immediately. After release, fetch restarts at `RESET_PC`; stale ROM data is not delivered.
